// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module : life_pkg
// Brief  : Shared window bit positions, width helper and scanner state type.
// Rev    : 1.0 - initial release
// ============================================================================
package life_pkg;

  // Window bit positions; the 9-bit window is packed in this order, LSB first.
  localparam int unsigned NB_TL    = 0;
  localparam int unsigned NB_T     = 1;
  localparam int unsigned NB_TR    = 2;
  localparam int unsigned NB_L     = 3;
  localparam int unsigned NB_C     = 4;
  localparam int unsigned NB_R     = 5;
  localparam int unsigned NB_BL    = 6;
  localparam int unsigned NB_B     = 7;
  localparam int unsigned NB_BR    = 8;
  localparam int unsigned NB_COUNT = 9;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_neigh_sel.sv
`default_nettype none
// ============================================================================
// Module : life_neigh_sel
// Brief  : Combinational 3x3 neighbourhood picker with dead or toroidal edges.
// Rev    : 1.0 - initial release
// ============================================================================
module life_neigh_sel
  import life_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned HEIGHT = 16,
  parameter bit          WRAP   = 1'b0,
  parameter int unsigned XW     = width_of(WIDTH),
  parameter int unsigned YW     = width_of(HEIGHT)
) (
  input  logic [WIDTH*HEIGHT-1:0] board_i,
  input  logic [XW-1:0]           x_i,
  input  logic [YW-1:0]           y_i,
  output logic [NB_COUNT-1:0]     win_o
);

  localparam int unsigned N  = WIDTH * HEIGHT;
  localparam int unsigned IW = width_of(N);

  logic          x_lo_w;
  logic          x_hi_w;
  logic          y_lo_w;
  logic          y_hi_w;
  logic [XW-1:0] col_w [3];
  logic [YW-1:0] row_w [3];
  logic [2:0]    col_ok_w;
  logic [2:0]    row_ok_w;

  assign x_lo_w = (x_i == '0);
  assign x_hi_w = (x_i == XW'(WIDTH - 1));
  assign y_lo_w = (y_i == '0);
  assign y_hi_w = (y_i == YW'(HEIGHT - 1));

  // Neighbour coordinates always land inside the board; the ok flags kill
  // the off-board ones when edges are dead.
  always_comb begin
    col_w[0] = x_lo_w ? XW'(WIDTH - 1) : x_i - XW'(1);
    col_w[1] = x_i;
    col_w[2] = x_hi_w ? '0 : x_i + XW'(1);
    row_w[0] = y_lo_w ? YW'(HEIGHT - 1) : y_i - YW'(1);
    row_w[1] = y_i;
    row_w[2] = y_hi_w ? '0 : y_i + YW'(1);
    col_ok_w = {WRAP | ~x_hi_w, 1'b1, WRAP | ~x_lo_w};
    row_ok_w = {WRAP | ~y_hi_w, 1'b1, WRAP | ~y_lo_w};
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      logic [IW-1:0] idx_w;
      assign idx_w = IW'(row_w[r]) * IW'(WIDTH) + IW'(col_w[c]);
      assign win_o[r*3 + c] = row_ok_w[r] & col_ok_w[c] & board_i[idx_w];
    end
  end

endmodule
`default_nettype wire

// File: rtl/life_window_scanner.sv
`default_nettype none
// ============================================================================
// Module : life_window_scanner
// Brief  : Loads a Life board bit-serially, then streams every cell's 3x3 window.
// Rev    : 1.0 - initial release
// ============================================================================
module life_window_scanner
  import life_pkg::*;
#(
  parameter int unsigned  WIDTH  = 16,
  parameter int unsigned  HEIGHT = 16,
  parameter bit           WRAP   = 1'b0,
  localparam int unsigned XW     = width_of(WIDTH),
  localparam int unsigned YW     = width_of(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_cell,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_tl,
  output logic          out_t,
  output logic          out_tr,
  output logic          out_l,
  output logic          out_c,
  output logic          out_r,
  output logic          out_bl,
  output logic          out_b,
  output logic          out_br,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned N  = WIDTH * HEIGHT;
  localparam int unsigned IW = width_of(N);

  if (WIDTH < 3 || HEIGHT < 3) begin : g_bad_dims
    $error("life_window_scanner: WIDTH and HEIGHT must both be >= 3");
  end

  state_e                state_q;
  logic [IW-1:0]         ld_idx_q;
  logic [XW-1:0]         sx_q;
  logic [YW-1:0]         sy_q;
  logic [N-1:0]          board_q;

  logic                  scan_w;
  logic                  in_hs_w;
  logic                  x_end_w;
  logic                  y_end_w;
  logic                  ld_end_w;
  logic [NB_COUNT-1:0]   win_w;

  assign scan_w   = (state_q == SCAN);
  assign in_hs_w  = in_valid & ~scan_w;
  assign x_end_w  = (sx_q == XW'(WIDTH - 1));
  assign y_end_w  = (sy_q == YW'(HEIGHT - 1));
  assign ld_end_w = (ld_idx_q == IW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      ld_idx_q <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      board_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_hs_w) begin
            board_q[ld_idx_q] <= in_cell;
            if (ld_end_w) begin
              ld_idx_q <= '0;
              state_q  <= SCAN;
            end else begin
              ld_idx_q <= ld_idx_q + IW'(1);
            end
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (x_end_w) begin
              sx_q <= '0;
              if (y_end_w) begin
                sy_q    <= '0;
                state_q <= LOAD;
              end else begin
                sy_q <= sy_q + YW'(1);
              end
            end else begin
              sx_q <= sx_q + XW'(1);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  life_neigh_sel #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .WRAP   (WRAP),
    .XW     (XW),
    .YW     (YW)
  ) u_neigh_sel (
    .board_i (board_q),
    .x_i     (sx_q),
    .y_i     (sy_q),
    .win_o   (win_w)
  );

  // Window bits are forced low outside SCAN so idle outputs never show stale data.
  assign in_ready  = ~scan_w;
  assign out_valid = scan_w;
  assign busy      = scan_w;
  assign out_tl    = scan_w & win_w[NB_TL];
  assign out_t     = scan_w & win_w[NB_T];
  assign out_tr    = scan_w & win_w[NB_TR];
  assign out_l     = scan_w & win_w[NB_L];
  assign out_c     = scan_w & win_w[NB_C];
  assign out_r     = scan_w & win_w[NB_R];
  assign out_bl    = scan_w & win_w[NB_BL];
  assign out_b     = scan_w & win_w[NB_B];
  assign out_br    = scan_w & win_w[NB_BR];
  assign out_x     = sx_q;
  assign out_y     = sy_q;
  assign out_last  = scan_w & x_end_w & y_end_w;

endmodule
`default_nettype wire

// File: tb/tb_life_window_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_life_window_scanner
// Brief  : Three scanner instances (5x5 dead, 5x5 wrap, 7x4 wrap) against a model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_life_window_scanner;

  localparam int ND   = 3;
  localparam int MAXN = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid  [ND];
  logic in_cell   [ND];
  logic out_ready [ND];
  wire  in_ready  [ND];
  wire  out_valid [ND];
  wire  out_last  [ND];
  wire  busy      [ND];
  wire [8:0] win  [ND];
  wire [2:0] ox   [ND];
  wire [2:0] oy   [ND];

  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int W  = (g == 2) ? 7 : 5;
    localparam int H  = (g == 2) ? 4 : 5;
    localparam bit WR = (g != 0);
    logic [$clog2(W)-1:0] x_w;
    logic [$clog2(H)-1:0] y_w;
    logic tl, t, tr, l, c, r, bl, b, br;
    life_window_scanner #(.WIDTH(W), .HEIGHT(H), .WRAP(WR)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_cell(in_cell[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_tl(tl), .out_t(t), .out_tr(tr), .out_l(l), .out_c(c), .out_r(r),
      .out_bl(bl), .out_b(b), .out_br(br),
      .out_x(x_w), .out_y(y_w), .out_last(out_last[g]), .busy(busy[g])
    );
    assign win[g] = {br, b, bl, r, c, l, tr, t, tl};
    assign ox[g]  = 3'(x_w);
    assign oy[g]  = 3'(y_w);
  end

  function automatic int dw(input int d);
    return (d == 2) ? 7 : 5;
  endfunction
  function automatic int dh(input int d);
    return (d == 2) ? 4 : 5;
  endfunction
  function automatic bit dwrap(input int d);
    return (d != 0);
  endfunction

  bit          ld  [ND][MAXN];
  bit          sc  [ND][MAXN];
  logic [8:0]  cap [ND][MAXN];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned t_first = 0;
  int unsigned t_lasths = 0;

  typedef struct {
    int         tag;
    int         d;
    int         x;
    int         y;
    logic [8:0] exp;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int d);
    n_cmp++;
    n_bad++;
    $display("FAIL %s dut%0d: cycle bound expired (t=%0t)", name, d, $time);
  endtask

  // Reference window: bit (dy+1)*3+(dx+1) holds cell (x+dx, y+dy).
  function automatic logic [8:0] ref_win(input int d, input int x, input int y);
    logic [8:0] w;
    w = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        int xx;
        int yy;
        bit in_b;
        xx = x + dx;
        yy = y + dy;
        in_b = 1'b1;
        if (dwrap(d)) begin
          xx = (xx + dw(d)) % dw(d);
          yy = (yy + dh(d)) % dh(d);
        end else if (xx < 0 || xx >= dw(d) || yy < 0 || yy >= dh(d)) begin
          in_b = 1'b0;
        end
        if (in_b) w[(dy + 1) * 3 + (dx + 1)] = sc[d][yy * dw(d) + xx];
      end
    end
    return w;
  endfunction

  task automatic fill(input int d, input int mode);
    for (int i = 0; i < MAXN; i++) begin
      ld[d][i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
    end
  endtask

  task automatic load_frame(input int d, input bit gaps);
    int n;
    int k;
    int guard;
    n = dw(d) * dh(d);
    k = 0;
    guard = 0;
    while (k < n && guard < 8 * n) begin
      chk("load_in_ready", d, 32'(in_ready[d]), 1);
      chk("load_out_valid", d, 32'(out_valid[d]), 0);
      if (gaps && $urandom_range(3) == 0) begin
        in_valid[d] = 1'b0;
      end else begin
        in_valid[d] = 1'b1;
        in_cell[d]  = ld[d][k];
        k++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid[d] = 1'b0;
    if (k < n) fail_now("load_timeout", d);
    for (int i = 0; i < n; i++) sc[d][i] = ld[d][i];
  endtask

  task automatic scan_frame(input int d, input bit bp7, input bit rnd);
    int n;
    int b;
    int stall;
    int guard;
    bit done;
    n = dw(d) * dh(d);
    b = 0;
    stall = 0;
    guard = 0;
    done = 1'b0;
    chk("first_beat_valid", d, 32'(out_valid[d]), 1);
    t_first = cyc_cnt;
    while (!done && guard < 4 * n + 20) begin
      if (out_valid[d]) begin
        chk("x", d, 32'(ox[d]), b % dw(d));
        chk("y", d, 32'(oy[d]), b / dw(d));
        chk("window", d, 32'(win[d]), 32'(ref_win(d, b % dw(d), b / dw(d))));
        chk("last", d, 32'(out_last[d]), (b == n - 1) ? 1 : 0);
        chk("busy", d, 32'(busy[d]), 1);
        chk("scan_in_ready", d, 32'(in_ready[d]), 0);
        if (bp7 && b == 7 && stall < 3) begin
          out_ready[d] = 1'b0;
          stall++;
        end else if (rnd && $urandom_range(4) == 0) begin
          out_ready[d] = 1'b0;
        end else begin
          out_ready[d] = 1'b1;
          cap[d][b] = win[d];
          if (b == n - 1) begin
            done = 1'b1;
            t_lasths = cyc_cnt;
          end
          b++;
        end
      end else begin
        chk("scan_valid", d, 32'(out_valid[d]), 1);
        out_ready[d] = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    out_ready[d] = 1'b0;
    if (!done) fail_now("scan_timeout", d);
    chk("beat_count", d, b, n);
    chk("post_out_valid", d, 32'(out_valid[d]), 0);
    chk("post_in_ready", d, 32'(in_ready[d]), 1);
    chk("post_busy", d, 32'(busy[d]), 0);
  endtask

  task automatic check_table(input int tag);
    for (int i = 0; i < 11; i++) begin
      if (vt[i].tag == tag) begin
        chk($sformatf("table_%0d_(%0d,%0d)", tag, vt[i].x, vt[i].y), vt[i].d,
            32'(cap[vt[i].d][vt[i].y * dw(vt[i].d) + vt[i].x]), 32'(vt[i].exp));
      end
    end
  endtask

  task automatic chk_idle(input string name, input int d);
    chk({name, "_in_ready"}, d, 32'(in_ready[d]), 1);
    chk({name, "_out_valid"}, d, 32'(out_valid[d]), 0);
    chk({name, "_busy"}, d, 32'(busy[d]), 0);
    chk({name, "_window"}, d, 32'(win[d]), 0);
    chk({name, "_x"}, d, 32'(ox[d]), 0);
    chk({name, "_y"}, d, 32'(oy[d]), 0);
    chk({name, "_last"}, d, 32'(out_last[d]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned saved;
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      in_cell[d]   = 1'b0;
      out_ready[d] = 1'b0;
    end
    // tag 0: blinker on dut0, tag 1: all-ones on dut0, tag 2: single cell on dut1
    vt[0]  = '{0, 0, 1, 2, 9'h124};
    vt[1]  = '{0, 0, 2, 2, 9'h092};
    vt[2]  = '{0, 0, 2, 0, 9'h080};
    vt[3]  = '{0, 0, 4, 4, 9'h000};
    vt[4]  = '{1, 0, 0, 0, 9'h1B0};
    vt[5]  = '{1, 0, 4, 4, 9'h01B};
    vt[6]  = '{2, 1, 4, 4, 9'h100};
    vt[7]  = '{2, 1, 1, 1, 9'h001};
    vt[8]  = '{2, 1, 4, 0, 9'h020};
    vt[9]  = '{2, 1, 0, 4, 9'h080};
    vt[10] = '{2, 1, 0, 0, 9'h010};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) chk_idle("reset", d);

    fill(0, 0);
    ld[0][7] = 1'b1;
    ld[0][12] = 1'b1;
    ld[0][17] = 1'b1;
    load_frame(0, 1'b1);
    scan_frame(0, 1'b0, 1'b0);
    check_table(0);

    fill(0, 1);
    load_frame(0, 1'b1);
    scan_frame(0, 1'b1, 1'b0);
    check_table(1);

    fill(1, 1);
    load_frame(1, 1'b0);
    scan_frame(1, 1'b1, 1'b1);

    fill(1, 0);
    ld[1][0] = 1'b1;
    load_frame(1, 1'b1);
    scan_frame(1, 1'b0, 1'b0);
    check_table(2);

    for (int rep = 0; rep < 2; rep++) begin
      for (int d = 0; d < ND; d++) begin
        fill(d, 2);
        load_frame(d, 1'b1);
        scan_frame(d, rep == 0, 1'b1);
      end
    end

    // Back-to-back frames with in_valid held high through the scan.
    fill(2, 2);
    load_frame(2, 1'b0);
    fill(2, 2);
    in_valid[2] = 1'b1;
    in_cell[2]  = ld[2][0];
    scan_frame(2, 1'b0, 1'b0);
    saved = t_lasths;
    load_frame(2, 1'b0);
    scan_frame(2, 1'b0, 1'b0);
    chk("b2b_latency", 2, t_first - saved, dw(2) * dh(2) + 1);

    // Reset in the middle of a scan.
    fill(0, 2);
    load_frame(0, 1'b1);
    out_ready[0] = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 0, 32'(busy[0]), 1);
    chk("pre_reset_y", 0, 32'(oy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset", 0);
    out_ready[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset", 0);
    fill(0, 0);
    load_frame(0, 1'b1);
    scan_frame(0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
